mac_tile_reconf: RTL and testbench

//  Single processing element of the reconfigurable systolic MAC array (row x col grid).

---
 rtl/mac_tile_reconf.sv | 105 ++++++++++
 tb/tb_mac_tile_reconf.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mac_tile_reconf.sv
// Purpose: one processing element of the reconfigurable systolic MAC array (weight- or output-stationary).
// Latency: every output is registered; each instruction takes effect on the next rising clk edge.
// Backpressure: none; the tile consumes its inputs on every cycle and has no handshake.
module mac_tile_reconf #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      in_w,
  input  logic [psum_bw-1:0] in_n,
  input  logic [2:0]         inst_w,
  output logic [psum_bw-1:0] out_s,
  output logic [bw-1:0]      out_e,
  output logic [2:0]         inst_e
);

  // Full-precision product width: (bw+1)-bit unsigned-as-signed activation times bw-bit signed weight.
  localparam int PW = 2 * bw + 1;

  logic [psum_bw-1:0] r_out_s;
  logic [bw-1:0]      r_out_e;
  logic [2:0]         r_inst_e;
  logic [psum_bw-1:0] r_acc;
  logic [bw-1:0]      r_w_q;
  logic               r_w_loaded;

  logic               w_mode;
  logic               w_exec;
  logic               w_load;
  logic [bw-1:0]      w_wt;
  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_wt_ext;
  logic signed [PW-1:0] w_prod;
  logic [psum_bw-1:0] w_prod_ext;
  logic [psum_bw-1:0] w_acc_sum;
  logic [psum_bw-1:0] w_ws_sum;

  assign w_mode = inst_w[2];
  assign w_exec = inst_w[1];
  assign w_load = inst_w[0];

  // OS takes the weight straight from the north stream; WS uses the stationary weight.
  assign w_wt = w_mode ? in_n[bw-1:0] : r_w_q;

  // Activation is unsigned, so it is zero-extended; the weight is sign-extended.
  assign w_a_ext    = {{(PW - bw){1'b0}}, in_w};
  assign w_wt_ext   = {{(PW - bw){w_wt[bw-1]}}, w_wt};
  assign w_prod     = w_a_ext * w_wt_ext;
  assign w_prod_ext = {{(psum_bw - PW){w_prod[PW-1]}}, w_prod};

  // Both sums wrap modulo 2^psum_bw; no saturation.
  assign w_acc_sum = r_acc + w_prod_ext;
  assign w_ws_sum  = in_n + w_prod_ext;

  // Pipeline registers, accumulator and stationary weight; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_s    <= '0;
      r_out_e    <= '0;
      r_inst_e   <= '0;
      r_acc      <= '0;
      r_w_q      <= '0;
      r_w_loaded <= 1'b0;
    end else begin
      r_inst_e <= inst_w;
      if (w_exec) begin
        r_out_e <= in_w;
      end
      if (w_mode) begin
        case ({w_exec, w_load})
          2'b10: begin
            r_acc   <= w_acc_sum;
            r_out_s <= in_n;
          end
          2'b01: begin
            r_out_s <= r_acc;
            r_acc   <= in_n;
          end
          2'b11: begin
            r_out_s <= r_acc;
            r_acc   <= '0;
          end
          default: begin
          end
        endcase
      end else if (w_load) begin
        // First load captures the weight; later loads pass weights on to tiles further south.
        if (!r_w_loaded) begin
          r_w_q      <= in_n[bw-1:0];
          r_w_loaded <= 1'b1;
        end else begin
          r_out_s <= in_n;
        end
      end else if (w_exec) begin
        r_out_s <= w_ws_sum;
      end
    end
  end

  assign out_s  = r_out_s;
  assign out_e  = r_out_e;
  assign inst_e = r_inst_e;

endmodule

// File: tb/tb_mac_tile_reconf.sv
// Directed bench for mac_tile_reconf: reset, OS accumulate/shift/flush, WS load/forward/execute, wrap, async reset.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// No handshake involved; every step is exactly one clock.
module tb_mac_tile_reconf;

  logic        clk;
  logic        reset;
  logic [3:0]  in_w;
  logic [15:0] in_n;
  logic [2:0]  inst_w;
  logic [15:0] out_s;
  logic [3:0]  out_e;
  logic [2:0]  inst_e;

  int n_checks = 0;
  int n_errors = 0;

  mac_tile_reconf #(.bw(4), .psum_bw(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .in_w   (in_w),
    .in_n   (in_n),
    .inst_w (inst_w),
    .out_s  (out_s),
    .out_e  (out_e),
    .inst_e (inst_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] inst, input logic [3:0] a, input logic [15:0] n);
    inst_w = inst;
    in_w   = a;
    in_n   = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset with random inputs
    reset = 1'b0;
    drive(3'($urandom), 4'($urandom), 16'($urandom));
    tick();
    drive(3'($urandom), 4'($urandom), 16'($urandom));
    tick();
    chk("rst_out_s", out_s, 16'h0000);
    chk("rst_out_e", {12'h0, out_e}, 16'h0000);
    chk("rst_inst_e", {13'h0, inst_e}, 16'h0000);
    reset = 1'b1;
    drive(3'b100, 4'd9, 16'h1234);
    tick();
    chk("idle_out_s", out_s, 16'h0000);
    chk("idle_out_e", {12'h0, out_e}, 16'h0000);
    chk("idle_inst_e", {13'h0, inst_e}, 16'h0004);

    // 2. OS accumulate: 3*2 + 5*(-1) + 15*(-8) = -119
    drive(3'b110, 4'd3, 16'h0002);
    tick();
    chk("os1_out_s", out_s, 16'h0002);
    chk("os1_out_e", {12'h0, out_e}, 16'h0003);
    chk("os1_inst_e", {13'h0, inst_e}, 16'h0006);
    drive(3'b110, 4'd5, 16'hFFFF);
    tick();
    chk("os2_out_s", out_s, 16'hFFFF);
    chk("os2_out_e", {12'h0, out_e}, 16'h0005);
    drive(3'b110, 4'd15, 16'hFFF8);
    tick();
    chk("os3_out_s", out_s, 16'hFFF8);
    chk("os3_out_e", {12'h0, out_e}, 16'h000F);

    // 3. Shift out acc and load 7, flush, shift again
    drive(3'b101, 4'd2, 16'h0007);
    tick();
    chk("shift_out_s", out_s, 16'hFF89);
    chk("shift_out_e_hold", {12'h0, out_e}, 16'h000F);
    drive(3'b111, 4'd0, 16'h0000);
    tick();
    chk("flush_out_s", out_s, 16'h0007);
    drive(3'b101, 4'd0, 16'h0000);
    tick();
    chk("shift0_out_s", out_s, 16'h0000);
    drive(3'b100, 4'd0, 16'h5555);
    tick();
    chk("os_idle_hold", out_s, 16'h0000);

    // 4. WS: load -3, forward 4, execute 6*(-3)+100 = 82
    drive(3'b001, 4'd0, 16'hFFFD);
    tick();
    chk("ws_load_out_s", out_s, 16'h0000);
    drive(3'b001, 4'd0, 16'h0004);
    tick();
    chk("ws_fwd_out_s", out_s, 16'h0004);
    drive(3'b010, 4'd6, 16'd100);
    tick();
    chk("ws_exec_out_s", out_s, 16'd82);
    chk("ws_exec_out_e", {12'h0, out_e}, 16'h0006);
    drive(3'b011, 4'd7, 16'h0005);
    tick();
    chk("ws_x11_load_wins", out_s, 16'h0005);
    drive(3'b000, 4'd1, 16'h0999);
    tick();
    chk("ws_hold_out_s", out_s, 16'h0005);
    chk("ws_hold_out_e", {12'h0, out_e}, 16'h0007);
    drive(3'b110, 4'd0, 16'h0000);
    tick();
    drive(3'b101, 4'd0, 16'h0000);
    tick();
    chk("ws_keeps_acc_zero", out_s, 16'h0000);

    // 5. WS wrap with fresh weight -8: 0x8000 + 15*(-8) = 0x7F88
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(3'b001, 4'd0, 16'hFFF8);
    tick();
    drive(3'b010, 4'd15, 16'h8000);
    tick();
    chk("ws_wrap_out_s", out_s, 16'h7F88);

    // OS wrap: acc=0x7FFF, WS cycle in between, then +1*1 -> 0x8000
    drive(3'b101, 4'd0, 16'h7FFF);
    tick();
    drive(3'b000, 4'd0, 16'h0000);
    tick();
    drive(3'b110, 4'd1, 16'h0001);
    tick();
    drive(3'b111, 4'd0, 16'h0000);
    tick();
    chk("os_wrap_out_s", out_s, 16'h8000);

    // 6. Async reset between edges during OS execute
    drive(3'b110, 4'd3, 16'h0002);
    tick();
    drive(3'b110, 4'd4, 16'h0003);
    tick();
    chk("pre_arst_out_s", out_s, 16'h0003);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_s", out_s, 16'h0000);
    chk("arst_out_e", {12'h0, out_e}, 16'h0000);
    chk("arst_inst_e", {13'h0, inst_e}, 16'h0000);
    tick();
    reset = 1'b1;
    drive(3'b110, 4'd2, 16'h0003);
    tick();
    drive(3'b101, 4'd0, 16'h0000);
    tick();
    chk("restart_acc", out_s, 16'h0006);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
